mem_ctrl: RTL and testbench

Single-port byte-wide RAM controller that arbitrates instruction fetch (IF) and data access (MEM) requests and produces the `stl_mm` stall that freezes the ID/EX pipeline register. It assembles or splits 32-bit words over an 8-bit synchronous RAM port, sign- or zero-extends loads, and holds the pipeline while a MEM access is in flight. It sits between the IF/MEM stages and the external RAM.

---
 rtl/mem_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller arbitrating IF/MEM requests; MEM_CTRL_PREFETCH_EN adds a one-word fetch buffer
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_st,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              stl_mm,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
  state_t r_state, w_state;
  logic [2:0] r_cnt, w_cnt, r_len, w_len;
  logic r_uns, w_uns;
  logic [ADDR_W-1:0] r_base, w_base, r_ram_a, w_ram_a, w_off;
  logic [31:0] r_buf, w_buf, w_asm, w_ext;
  logic [31:0] r_if_data, w_if_data, r_mem_rdata, w_mem_rdata;
  logic [7:0] r_ram_dout, w_dout;
  logic r_ram_we, w_we, r_if_done, w_if_done, r_mem_done, w_mem_done;
  logic [1:0] w_idx;
  logic w_abort;
  logic w_unused;
`ifdef MEM_CTRL_PREFETCH_EN
  logic r_pf, w_pf, r_pv, w_pv, r_ppend, w_ppend;
  logic [ADDR_W-1:0] r_ptag, w_ptag, r_pnxt, w_pnxt;
  logic [31:0] r_pbuf, w_pbuf;
  assign w_abort = r_pf ? mem_req : ~if_req;
`else
  assign w_abort = ~if_req;
`endif
  assign w_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
  assign w_off = r_base + ADDR_W'(r_cnt + 3'd1);
  assign w_idx = r_cnt[1:0] - 2'd1;
  assign stl_mm = mem_req & ~r_mem_done;
  assign ram_a = r_ram_a;
  assign ram_dout = r_ram_dout;
  assign ram_we = r_ram_we;
  assign if_data = r_if_data;
  assign if_done = r_if_done;
  assign mem_rdata = r_mem_rdata;
  assign mem_done = r_mem_done;
  // next-state, RAM port drive and read-byte assembly
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 3'd1;
    w_len = r_len;
    w_uns = r_uns;
    w_base = r_base;
    w_buf = r_buf;
    w_ram_a = r_ram_a;
    w_dout = r_ram_dout;
    w_we = 1'b0;
    w_if_done = 1'b0;
    w_mem_done = 1'b0;
    w_if_data = r_if_data;
    w_mem_rdata = r_mem_rdata;
    w_asm = r_buf;
    w_asm[8*w_idx +: 8] = ram_din;
    w_ext = r_len == 3'd1 ? {{24{~r_uns & w_asm[7]}}, w_asm[7:0]} :
            r_len == 3'd2 ? {{16{~r_uns & w_asm[15]}}, w_asm[15:0]} : w_asm;
`ifdef MEM_CTRL_PREFETCH_EN
    w_pf = r_pf;
    w_pv = r_pv;
    w_ppend = r_ppend;
    w_ptag = r_ptag;
    w_pnxt = r_pnxt;
    w_pbuf = r_pbuf;
`endif
    case (r_state)
      IDLE: begin
        w_cnt = 3'd0;
        if (mem_req) begin
          w_base = mem_addr[ADDR_W-1:0];
          w_ram_a = mem_addr[ADDR_W-1:0];
          w_len = mem_st[1:0] == 2'b00 ? 3'd1 : mem_st[1:0] == 2'b01 ? 3'd2 : 3'd4;
          w_uns = mem_st[2];
          w_buf = mem_wdata;
          w_dout = mem_wdata[7:0];
          w_we = mem_we;
          w_state = mem_we ? MEM_WR : MEM_RD;
`ifdef MEM_CTRL_PREFETCH_EN
          w_ppend = 1'b0;
          w_pv = r_pv & ~mem_we;
`endif
        end else if (if_req) begin
          w_base = if_addr[ADDR_W-1:0];
          w_ram_a = if_addr[ADDR_W-1:0];
          w_len = 3'd4;
          w_state = IF_RD;
`ifdef MEM_CTRL_PREFETCH_EN
          w_pf = 1'b0;
          if (r_pv && r_ptag == if_addr[ADDR_W-1:0]) begin
            w_state = DONE;
            w_if_done = 1'b1;
            w_if_data = r_pbuf;
            w_ppend = 1'b1;
            w_pnxt = if_addr[ADDR_W-1:0] + ADDR_W'(4);
          end
`endif
        end
`ifdef MEM_CTRL_PREFETCH_EN
        else if (r_ppend) begin
          w_pf = 1'b1;
          w_ppend = 1'b0;
          w_base = r_pnxt;
          w_ram_a = r_pnxt;
          w_len = 3'd4;
          w_state = IF_RD;
        end
`endif
      end
      IF_RD, MEM_RD: begin
        w_buf = w_asm;
        w_ram_a = w_off;
        if (r_state == IF_RD && w_abort) begin
          w_state = IDLE;
`ifdef MEM_CTRL_PREFETCH_EN
          w_pv = r_pv & ~r_pf;
`endif
        end else if (r_cnt == r_len) begin
          w_state = DONE;
          if (r_state == MEM_RD) begin
            w_mem_done = 1'b1;
            w_mem_rdata = w_ext;
          end else begin
            w_if_done = 1'b1;
            w_if_data = w_asm;
`ifdef MEM_CTRL_PREFETCH_EN
            w_ppend = 1'b1;
            w_pnxt = r_base + ADDR_W'(4);
            if (r_pf) begin
              w_state = IDLE;
              w_if_done = 1'b0;
              w_if_data = r_if_data;
              w_ppend = 1'b0;
              w_pv = 1'b1;
              w_ptag = r_base;
              w_pbuf = w_asm;
            end
`endif
          end
        end
      end
      MEM_WR: begin
        w_buf = {8'h00, r_buf[31:8]};
        w_dout = r_buf[15:8];
        w_ram_a = w_off;
        if (r_cnt + 3'd1 == r_len) begin
          w_state = DONE;
          w_mem_done = 1'b1;
        end else w_we = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_len <= '0;
      r_uns <= 1'b0;
      r_base <= '0;
      r_buf <= '0;
      r_ram_a <= '0;
      r_ram_dout <= '0;
      r_ram_we <= 1'b0;
      r_if_done <= 1'b0;
      r_mem_done <= 1'b0;
      r_if_data <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_len <= w_len;
      r_uns <= w_uns;
      r_base <= w_base;
      r_buf <= w_buf;
      r_ram_a <= w_ram_a;
      r_ram_dout <= w_dout;
      r_ram_we <= w_we;
      r_if_done <= w_if_done;
      r_mem_done <= w_mem_done;
      r_if_data <= w_if_data;
      r_mem_rdata <= w_mem_rdata;
    end
  end
`ifdef MEM_CTRL_PREFETCH_EN
  // fetch buffer and prefetch bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pf <= 1'b0;
      r_pv <= 1'b0;
      r_ppend <= 1'b0;
      r_ptag <= '0;
      r_pnxt <= '0;
      r_pbuf <= '0;
    end else begin
      r_pf <= w_pf;
      r_pv <= w_pv;
      r_ppend <= w_ppend;
      r_ptag <= w_ptag;
      r_pnxt <= w_pnxt;
      r_pbuf <= w_pbuf;
    end
  end
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a synchronous byte RAM model
module tb_mem_ctrl;
  localparam int AW = 17;
`ifdef MEM_CTRL_PREFETCH_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 5;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, if_done, mem_req = 1'b0, mem_we = 1'b0, mem_done, stl_mm, ram_we;
  logic [31:0] if_addr = '0, if_data, mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [2:0] mem_st = '0;
  logic [AW-1:0] ram_a;
  logic [7:0] ram_dout, ram_din;
  logic tb_we = 1'b0;
  logic [AW-1:0] tb_a = '0;
  logic [7:0] tb_d = '0;
  logic [7:0] ram [0:(1<<AW)-1];
  logic [31:0] qm[$], qi[$];
  int n_tests = 0, n_fail = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_st(mem_st), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .stl_mm(stl_mm),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // synchronous RAM with a bench-side preload port
  always @(posedge clk) begin
    if (ram_we) ram[ram_a] <= ram_dout;
    if (tb_we) ram[tb_a] <= tb_d;
    ram_din <= ram[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke32(input logic [AW-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_a = a + AW'(k);
      tb_d = w[8*k +: 8];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] st, input logic [31:0] a);
    logic [AW-1:0] b;
    logic [31:0] w;
    b = a[AW-1:0];
    w = {ram[b + AW'(3)], ram[b + AW'(2)], ram[b + AW'(1)], ram[b]};
    case (st)
      3'b000: return {{24{w[7]}}, w[7:0]};
      3'b001: return {{16{w[15]}}, w[15:0]};
      3'b100: return {24'h0, w[7:0]};
      3'b101: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mem_op(input logic we, input logic [2:0] st, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat, input string tag);
    int lat, stl, wec;
    logic done;
    if (!we) qm.push_back(ref_load(st, a));
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_st = st; mem_addr = a; mem_wdata = wd;
    #1;
    stl = stl_mm ? 1 : 0;
    lat = 0; wec = 0; done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (mem_done) begin
        done = 1'b1;
        lat = i - 1;
        chk({tag, "_stl_done"}, stl_mm, 0);
        chk({tag, "_we_done"}, ram_we, 0);
      end else begin
        if (stl_mm) stl++;
        if (ram_we) wec++;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      if (!we) void'(qm.pop_front());
    end else begin
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_stl_cycles"}, stl, exp_lat + 1);
      if (we) chk({tag, "_we_cycles"}, wec, exp_lat);
      else chk({tag, "_data"}, mem_rdata, qm.pop_front());
    end
    mem_req = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic if_op(input logic [31:0] a, input int exp_lat, input string tag);
    int lat;
    logic done;
    qi.push_back(ref_load(3'b010, a));
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    lat = 0; done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (if_done) begin
        done = 1'b1;
        lat = i - 1;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(qi.pop_front());
    end else begin
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_data"}, if_data, qi.pop_front());
    end
    if_req = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int mi, ii;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_dout", ram_dout, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_stl", stl_mm, 0);
    rst = 1'b0;
    poke32(AW'('h100), 32'h12345678);
    poke32(AW'('h300), 32'h00000080);
    poke32(AW'('h1FFFC), 32'h34000000);
    poke32(AW'('h0), 32'h00000092);
    poke32(AW'('h200), 32'h005A0000);
    poke32(AW'('h600), 32'hCAFEF00D);
    mem_op(1'b0, 3'b010, 32'h100, 0, 5, "lw");
    mem_op(1'b0, 3'b000, 32'h300, 0, 2, "lb");
    mem_op(1'b0, 3'b100, 32'h300, 0, 2, "lbu");
    mem_op(1'b0, 3'b001, 32'h1FFFF, 0, 3, "lh_wrap");
    mem_op(1'b0, 3'b101, 32'h1FFFF, 0, 3, "lhu_wrap");
    mem_op(1'b1, 3'b001, 32'h200, 32'hAABBCCDD, 2, "sh");
    chk("sh_b0", ram[AW'('h200)], 8'hDD);
    chk("sh_b1", ram[AW'('h201)], 8'hCC);
    chk("sh_b2", ram[AW'('h202)], 8'h5A);
    mem_op(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, 4, "sw");
    mem_op(1'b0, 3'b010, 32'h400, 0, 5, "lw_back");
    chk("lw_back_model", ref_load(3'b010, 32'h400), 32'hDEADBEEF);
    qm.push_back(ref_load(3'b000, 32'h300));
    qi.push_back(ref_load(3'b010, 32'h100));
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_st = 3'b000; mem_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    mi = 0; ii = 0;
    for (int i = 1; i <= 40 && ii == 0; i++) begin
      @(negedge clk);
      if (mem_done) begin
        mi = i;
        chk("both_mem_data", mem_rdata, qm.pop_front());
        mem_req = 1'b0;
      end
      if (if_done) begin
        ii = i;
        chk("both_if_data", if_data, qi.pop_front());
        if_req = 1'b0;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    chk("both_mem_cycle", mi, 3);
    chk("both_if_cycle", ii, 10);
    repeat (10) @(negedge clk);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    repeat (2) @(negedge clk);
    if_req = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_data_kept", if_data, 32'h12345678);
    if_op(32'h600, 5, "after_abort");
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_st = 3'b010; mem_addr = 32'h500; mem_wdata = 32'h01020304;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ram_we", ram_we, 0);
    chk("rstmid_mem_done", mem_done, 0);
    chk("rstmid_ram_a", ram_a, 0);
    chk("rstmid_ram_dout", ram_dout, 0);
    chk("rstmid_if_data", if_data, 0);
    chk("rstmid_mem_rdata", mem_rdata, 0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("rstmid_ram_we_idle", ram_we, 0);
    mem_op(1'b0, 3'b010, 32'h100, 0, 5, "lw_after_rst");
    poke32(AW'('h0), 32'h03020100);
    poke32(AW'('h4), 32'h07060504);
    poke32(AW'('h10), 32'h13121110);
    poke32(AW'('h14), 32'h17161514);
    if_op(32'h0, 5, "pf_f0");
    if_op(32'h4, HIT_LAT, "pf_f4");
    if_op(32'h10, 5, "pf_f10");
    mem_op(1'b1, 3'b010, 32'h200, 32'h11223344, 4, "pf_sw");
    if_op(32'h14, 5, "pf_f14");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
